// File: rtl/seq_chunk_adder_pkg.sv
// Shared types and elaboration helpers for seq_chunk_adder.
package seq_chunk_adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int unsigned calc_nsteps(input int unsigned width,
                                              input int unsigned chunk);
    return width / chunk;
  endfunction

  // Step counter needs at least one bit even when a single step suffices.
  function automatic int unsigned cnt_width(input int unsigned nsteps);
    return (nsteps <= 1) ? 1 : $clog2(nsteps);
  endfunction

endpackage

// File: rtl/seq_chunk_adder_fa_chain.sv
// Combinational CHUNK-bit ripple of full-adder cells; also exposes the carry
// into the top bit so the caller can derive signed overflow.
module fa_chain #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] sum,
  output logic             co,
  output logic             c_msb
);

  logic [CHUNK:0] w_c;

  always_comb begin
    w_c    = '0;
    sum    = '0;
    w_c[0] = ci;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      sum[i]   = x[i] ^ y[i] ^ w_c[i];
      w_c[i+1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
    end
    co    = w_c[CHUNK];
    c_msb = w_c[CHUNK-1];
  end

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder: CHUNK bits per clock behind a start/done handshake.
// Define SEQ_CHUNK_ADDER_SUB_EN to add the sub port (a + ~b + 1 when sub=1).
module seq_chunk_adder
  import seq_chunk_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SEQ_CHUNK_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V
);

  localparam int unsigned    NSTEPS = calc_nsteps(WIDTH, CHUNK);
  localparam int unsigned    CW     = cnt_width(NSTEPS);
  localparam logic [CW-1:0]  LAST_K = CW'(NSTEPS - 1);

  generate
    if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
      $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [CW-1:0]    r_k;

  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin_eff;
  logic [CHUNK-1:0] w_x;
  logic [CHUNK-1:0] w_y;
  logic [CHUNK-1:0] w_chunk_sum;
  logic             w_co;
  logic             w_c_msb;
  logic [WIDTH-1:0] w_sum_full;

  // Subtraction is folded in at capture time so the datapath only ever adds.
`ifdef SEQ_CHUNK_ADDER_SUB_EN
  assign w_b_eff   = sub ? ~b : b;
  assign w_cin_eff = sub ? 1'b1 : cin;
`else
  assign w_b_eff   = b;
  assign w_cin_eff = cin;
`endif

  always_comb begin
    w_x = r_a[r_k*CHUNK +: CHUNK];
    w_y = r_b[r_k*CHUNK +: CHUNK];
  end

  fa_chain #(
    .CHUNK(CHUNK)
  ) u_fa_chain (
    .x    (w_x),
    .y    (w_y),
    .ci   (r_carry),
    .sum  (w_chunk_sum),
    .co   (w_co),
    .c_msb(w_c_msb)
  );

  // Working sum with the current chunk merged in; on the last step this is the result.
  always_comb begin
    w_sum_full                      = r_sum;
    w_sum_full[r_k*CHUNK +: CHUNK]  = w_chunk_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_k     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      S       <= '0;
      Cout    <= 1'b0;
      V       <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= w_b_eff;
            r_carry <= w_cin_eff;
            r_k     <= '0;
            busy    <= 1'b1;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_sum   <= w_sum_full;
          r_carry <= w_co;
          if (r_k == LAST_K) begin
            S       <= w_sum_full;
            Cout    <= w_co;
            V       <= w_co ^ w_c_msb;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_k     <= '0;
            r_state <= DONE;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Self-checking bench for seq_chunk_adder (WIDTH=16, CHUNK=4) against an arithmetic model.
module tb_seq_chunk_adder;

  localparam int WIDTH  = 16;
  localparam int CHUNK  = 4;
  localparam int NSTEPS = WIDTH / CHUNK;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        busy;
  logic        done;
  logic [15:0] S;
  logic        Cout;
  logic        V;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_S;
  logic        exp_C;
  logic        exp_V;

  seq_chunk_adder #(
    .WIDTH(WIDTH),
    .CHUNK(CHUNK)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    .sub  (sub),
`endif
    .busy (busy),
    .done (done),
    .S    (S),
    .Cout (Cout),
    .V    (V)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain 17-bit arithmetic; returns {V, Cout, S}.
  function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic mc, input logic ms);
    logic [16:0] full;
    logic [15:0] bb;
    logic        cc;
    logic        ov;
    bb = mb;
    cc = mc;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    if (ms) begin
      bb = ~mb;
      cc = 1'b1;
    end
`else
    if (ms) cc = mc;
`endif
    full = {1'b0, ma} + {1'b0, bb} + {16'd0, cc};
    ov   = (ma[15] == bb[15]) && (full[15] != ma[15]);
    return {ov, full[16], full[15:0]};
  endfunction

  // Starts an op from IDLE/DONE (called at posedge+1); returns in the DONE cycle.
  // inj >= 0 raises start with zero operands during that RUN cycle (must be ignored).
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tbv, input logic tc,
                        input logic ts, input int inj);
    logic [17:0] m;
    int          busy_cnt;
    m     = model(ta, tbv, tc, ts);
    a     = ta;
    b     = tbv;
    cin   = tc;
    sub   = ts;
    start = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < NSTEPS; i++) begin
      if (i == inj) begin
        a     = 16'h0000;
        b     = 16'h0000;
        cin   = 1'b0;
        start = 1'b1;
      end else if (i == inj + 1) begin
        start = 1'b0;
      end
      if (busy === 1'b1) busy_cnt++;
      checks++;
      if (done !== 1'b0 || S !== exp_S || Cout !== exp_C || V !== exp_V) begin
        errors++;
        $display("FAIL run_hold step %0d: done=%b S=%h C=%b V=%b, expected done=0 S=%h C=%b V=%b",
                 i, done, S, Cout, V, exp_S, exp_C, exp_V);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    checks++;
    if (busy_cnt != NSTEPS) begin
      errors++;
      $display("FAIL busy_len: got %0d cycles, expected %0d", busy_cnt, NSTEPS);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL done_pulse: busy=%b done=%b, expected busy=0 done=1", busy, done);
    end
    checks++;
    if (S !== m[15:0] || Cout !== m[16] || V !== m[17]) begin
      errors++;
      $display("FAIL result a=%h b=%h cin=%b sub=%b: S=%h C=%b V=%b, expected S=%h C=%b V=%b",
               ta, tbv, tc, ts, S, Cout, V, m[15:0], m[16], m[17]);
    end
    exp_S = m[15:0];
    exp_C = m[16];
    exp_V = m[17];
  endtask

  task automatic idle_gap();
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || S !== exp_S || Cout !== exp_C || V !== exp_V) begin
      errors++;
      $display("FAIL idle_hold: done=%b busy=%b S=%h C=%b V=%b, expected 0 0 %h %b %b",
               done, busy, S, Cout, V, exp_S, exp_C, exp_V);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    sub   = 1'b0;
    exp_S = '0;
    exp_C = 1'b0;
    exp_V = 1'b0;
    #12;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || S !== 16'h0 || Cout !== 1'b0 || V !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b S=%h C=%b V=%b, expected all 0",
               busy, done, S, Cout, V);
    end
  endtask

  task automatic test_directed();
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, -1);
    idle_gap();
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, -1);
    idle_gap();
    run_op(16'h7FFF, 16'h0000, 1'b1, 1'b0, -1);
    idle_gap();
  endtask

  task automatic test_back_to_back();
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 1);
    checks++;
    if (S !== 16'h0002) begin
      errors++;
      $display("FAIL ignored_start: S=%h, expected 0002", S);
    end
    run_op(16'hA5A5, 16'h1111, 1'b1, 1'b0, -1);
    idle_gap();
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      logic        rc;
      logic        rs;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1));
`ifdef SEQ_CHUNK_ADDER_SUB_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      run_op(ra, rb, rc, rs, -1);
      if ($urandom_range(0, 1) == 0) idle_gap();
    end
    idle_gap();
  endtask

`ifdef SEQ_CHUNK_ADDER_SUB_EN
  task automatic test_sub();
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, -1);
    idle_gap();
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, -1);
    idle_gap();
  endtask
`endif

  task automatic test_reset_mid_run();
    a     = 16'h0F0F;
    b     = 16'h00FF;
    cin   = 1'b1;
    sub   = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || S !== 16'h0 || Cout !== 1'b0 || V !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_run: busy=%b done=%b S=%h C=%b V=%b, expected all 0",
               busy, done, S, Cout, V);
    end
    exp_S = '0;
    exp_C = 1'b0;
    exp_V = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < NSTEPS + 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || S !== 16'h0) begin
        errors++;
        $display("FAIL post_reset_quiet cycle %0d: done=%b busy=%b S=%h, expected 0 0 0000",
                 i, done, busy, S);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    test_sub();
`endif
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
